ex_hazard_ctrl: RTL and testbench

- Sequences the EX stage of the 5-stage RISC-TOY pipeline (IF, ID, EX, MEM, WB).
- Keeps a shadow pipeline of EX/MEM/WB destination-register tags.
- Detects load-use hazards and stalls IF/ID, inserting a bubble into EX.
- Flushes on branches/jumps taken in EX and drives registered forwarding selects for the EX operand muxes (data1/data2).
- Keeps saturating stall and flush counters for debug.

---
 rtl/ex_hazard_ctrl_pkg.sv | 50 +++++
 rtl/hazard_sat_counter.sv | 19 +
 rtl/ex_hazard_ctrl.sv | 118 +++++++++++
 tb/tb_ex_hazard_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ex_hazard_ctrl_pkg.sv
// Shared definitions for the EX-stage hazard controller of the RISC-TOY pipeline.
package ex_hazard_ctrl_pkg;

  localparam int unsigned REG_W_DEFAULT = 5;

  // RISC-TOY 5-bit opcodes.
  typedef enum logic [4:0] {
    ADDI = 5'd0,
    ANDI = 5'd1,
    ORI  = 5'd2,
    MOVI = 5'd3,
    ADD  = 5'd4,
    SUB  = 5'd5,
    NEG  = 5'd6,
    NOT  = 5'd7,
    AND  = 5'd8,
    OR   = 5'd9,
    XOR  = 5'd10,
    LSR  = 5'd11,
    ASR  = 5'd12,
    SHL  = 5'd13,
    ROR  = 5'd14,
    BR   = 5'd15,
    BRL  = 5'd16,
    J    = 5'd17,
    JL   = 5'd18,
    LD   = 5'd19,
    LDR  = 5'd20,
    ST   = 5'd21,
    STR  = 5'd22
  } opcode_e;

  // EX operand mux source selects.
  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

  // Newest producer wins: the instruction currently in EX beats the one in MEM.
  function automatic fwd_sel_e pick_fwd(input logic ex_hit, input logic mem_hit);
    if (ex_hit)
      return FWD_EXMEM;
    else if (mem_hit)
      return FWD_MEMWB;
    else
      return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter used for the stall/flush debug counters.
module hazard_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Count qualifying cycles, holding at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard controller: shadow EX/MEM/WB destination tags, load-use
// stall, taken-branch flush, registered forwarding selects, debug counters.
module ex_hazard_ctrl
  import ex_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_W = REG_W_DEFAULT,
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src1,
  input  logic             id_src1_en,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_src2_en,
  input  logic [REG_W-1:0] id_dst,
  input  logic             id_dst_en,
  input  logic             id_is_load,
  input  logic             ex_br_taken,
  output logic             stall,
  output logic             flush_ifid,
  output logic             ex_valid,
  output logic [1:0]       fwd_sel1,
  output logic [1:0]       fwd_sel2,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Shadow pipeline entries
  logic             ex_v, ex_dst_en, ex_ld;
  logic [REG_W-1:0] ex_dst;
  logic             mem_v, mem_dst_en;
  logic [REG_W-1:0] mem_dst;
  logic             wb_v, wb_dst_en;
  logic [REG_W-1:0] wb_dst;

  fwd_sel_e fwd1_q, fwd2_q;
  fwd_sel_e fwd1_d, fwd2_d;

  logic ex_hit1, ex_hit2, mem_hit1, mem_hit2;
  logic load_use, take_id;

  // The WB entry retires this edge and the regfile write is visible in ID,
  // so it is tracked but never a forwarding source.
  logic wb_unused;
  assign wb_unused = ^{wb_v, wb_dst_en, wb_dst};

  // Hazard detection and next forwarding selects for the instruction in ID.
  always_comb begin
    ex_hit1  = ex_v & ex_dst_en & (ex_dst == id_src1);
    ex_hit2  = ex_v & ex_dst_en & (ex_dst == id_src2);
    mem_hit1 = mem_v & mem_dst_en & (mem_dst == id_src1);
    mem_hit2 = mem_v & mem_dst_en & (mem_dst == id_src2);

    flush_ifid = ex_v & ex_br_taken;
    load_use   = id_valid & ex_ld & ((id_src1_en & ex_hit1) | (id_src2_en & ex_hit2));
    // A flushed dependent is squashed anyway, so flush wins over stall.
    stall      = load_use & ~flush_ifid;
    take_id    = id_valid & ~flush_ifid & ~stall;

    fwd1_d = FWD_RF;
    fwd2_d = FWD_RF;
    if (take_id && id_src1_en)
      fwd1_d = pick_fwd(ex_hit1, mem_hit1);
    if (take_id && id_src2_en)
      fwd2_d = pick_fwd(ex_hit2, mem_hit2);
  end

  // Advance the shadow pipeline and register the forwarding selects.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      ex_v       <= 1'b0;
      ex_dst     <= '0;
      ex_dst_en  <= 1'b0;
      ex_ld      <= 1'b0;
      mem_v      <= 1'b0;
      mem_dst    <= '0;
      mem_dst_en <= 1'b0;
      wb_v       <= 1'b0;
      wb_dst     <= '0;
      wb_dst_en  <= 1'b0;
      fwd1_q     <= FWD_RF;
      fwd2_q     <= FWD_RF;
    end else begin
      wb_v       <= mem_v;
      wb_dst     <= mem_dst;
      wb_dst_en  <= mem_dst_en;
      mem_v      <= ex_v;
      mem_dst    <= ex_dst;
      mem_dst_en <= ex_dst_en;
      ex_v       <= take_id;
      ex_dst     <= id_dst;
      ex_dst_en  <= id_dst_en & take_id;
      ex_ld      <= id_is_load & take_id;
      fwd1_q     <= fwd1_d;
      fwd2_q     <= fwd2_d;
    end
  end

  assign ex_valid = ex_v;
  assign fwd_sel1 = fwd1_q;
  assign fwd_sel2 = fwd2_q;

  hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (CLK),
    .rst_n (RSTN),
    .inc   (stall),
    .count (stall_cnt)
  );

  hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (CLK),
    .rst_n (RSTN),
    .inc   (flush_ifid),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed bench for ex_hazard_ctrl with 4-bit counters to reach saturation.
module tb_ex_hazard_ctrl;

  localparam int unsigned CW = 4;

  logic          CLK;
  logic          RSTN;
  logic          id_valid;
  logic [4:0]    id_src1;
  logic          id_src1_en;
  logic [4:0]    id_src2;
  logic          id_src2_en;
  logic [4:0]    id_dst;
  logic          id_dst_en;
  logic          id_is_load;
  logic          ex_br_taken;
  logic          stall;
  logic          flush_ifid;
  logic          ex_valid;
  logic [1:0]    fwd_sel1;
  logic [1:0]    fwd_sel2;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;

  int checks = 0;
  int failures = 0;

  ex_hazard_ctrl #(.REG_W(5), .CNT_W(CW)) dut (
    .CLK         (CLK),
    .RSTN        (RSTN),
    .id_valid    (id_valid),
    .id_src1     (id_src1),
    .id_src1_en  (id_src1_en),
    .id_src2     (id_src2),
    .id_src2_en  (id_src2_en),
    .id_dst      (id_dst),
    .id_dst_en   (id_dst_en),
    .id_is_load  (id_is_load),
    .ex_br_taken (ex_br_taken),
    .stall       (stall),
    .flush_ifid  (flush_ifid),
    .ex_valid    (ex_valid),
    .fwd_sel1    (fwd_sel1),
    .fwd_sel2    (fwd_sel2),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] s1, input logic s1e,
                       input logic [4:0] s2, input logic s2e,
                       input logic [4:0] d, input logic de, input logic ld);
    id_valid   = v;
    id_src1    = s1;
    id_src1_en = s1e;
    id_src2    = s2;
    id_src2_en = s2e;
    id_dst     = d;
    id_dst_en  = de;
    id_is_load = ld;
    #1;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RSTN = 1'b0;
    ex_br_taken = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // Reset state
    tick();
    tick();
    chk("rst_stall", 16'(stall), 16'd0);
    chk("rst_flush", 16'(flush_ifid), 16'd0);
    chk("rst_ex_valid", 16'(ex_valid), 16'd0);
    chk("rst_sel1", 16'(fwd_sel1), 16'd0);
    chk("rst_sel2", 16'(fwd_sel2), 16'd0);
    chk("rst_stall_cnt", 16'(stall_cnt), 16'd0);
    chk("rst_flush_cnt", 16'(flush_cnt), 16'd0);
    RSTN = 1'b1;

    // ADD R3<-R1,R2 ; SUB R4<-R3,R5
    drive(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0);
    chk("add_stall", 16'(stall), 16'd0);
    tick();
    chk("add_ex_valid", 16'(ex_valid), 16'd1);
    chk("add_sel1", 16'(fwd_sel1), 16'd0);
    chk("add_sel2", 16'(fwd_sel2), 16'd0);
    drive(1, 5'd3, 1, 5'd5, 1, 5'd4, 1, 0);
    chk("sub_stall", 16'(stall), 16'd0);
    tick();
    chk("sub_ex_valid", 16'(ex_valid), 16'd1);
    chk("sub_sel1", 16'(fwd_sel1), 16'd1);
    chk("sub_sel2", 16'(fwd_sel2), 16'd0);

    // Distance two: ADD R3 ; NOT R7<-R9 ; OR R10<-R11,R3
    drive(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0);
    tick();
    drive(1, 5'd9, 1, 5'd0, 0, 5'd7, 1, 0);
    tick();
    drive(1, 5'd11, 1, 5'd3, 1, 5'd10, 1, 0);
    tick();
    chk("dist2_sel1", 16'(fwd_sel1), 16'd0);
    chk("dist2_sel2", 16'(fwd_sel2), 16'd2);

    // Distance three, plus a disabled source that would otherwise match MEM
    drive(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0);
    tick();
    drive(1, 5'd9, 1, 5'd0, 0, 5'd7, 1, 0);
    tick();
    drive(1, 5'd9, 1, 5'd3, 0, 5'd7, 1, 0);
    tick();
    chk("disabled_src_sel2", 16'(fwd_sel2), 16'd0);
    drive(1, 5'd11, 1, 5'd3, 1, 5'd10, 1, 0);
    tick();
    chk("dist3_sel2", 16'(fwd_sel2), 16'd0);

    // Both EX and MEM produce R3: the newer (EX) wins
    drive(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0);
    tick();
    drive(1, 5'd3, 1, 5'd1, 1, 5'd3, 1, 0);
    tick();
    chk("chain_sel1", 16'(fwd_sel1), 16'd1);
    drive(1, 5'd3, 1, 5'd3, 1, 5'd5, 1, 0);
    tick();
    chk("newer_sel1", 16'(fwd_sel1), 16'd1);
    chk("newer_sel2", 16'(fwd_sel2), 16'd1);

    // Bubble from idle ID
    drive(0, 5'd3, 1, 5'd3, 1, 5'd3, 1, 0);
    tick();
    chk("idle_ex_valid", 16'(ex_valid), 16'd0);
    chk("idle_sel1", 16'(fwd_sel1), 16'd0);

    // Load-use: LD R6<-[R1+4] ; ADD R8<-R6,R6
    drive(1, 5'd1, 1, 5'd0, 0, 5'd6, 1, 1);
    chk("ld_stall", 16'(stall), 16'd0);
    tick();
    drive(1, 5'd6, 1, 5'd6, 1, 5'd8, 1, 0);
    chk("lu_stall", 16'(stall), 16'd1);
    chk("lu_flush", 16'(flush_ifid), 16'd0);
    tick();
    chk("lu_bubble_ex_valid", 16'(ex_valid), 16'd0);
    chk("lu_stall_one_cycle", 16'(stall), 16'd0);
    chk("lu_stall_cnt", 16'(stall_cnt), 16'd1);
    tick();
    chk("lu_ex_valid", 16'(ex_valid), 16'd1);
    chk("lu_sel1", 16'(fwd_sel1), 16'd2);
    chk("lu_sel2", 16'(fwd_sel2), 16'd2);

    // Taken branch in EX together with a load-use condition: flush wins
    drive(1, 5'd1, 1, 5'd0, 0, 5'd12, 1, 1);
    tick();
    ex_br_taken = 1'b1;
    drive(1, 5'd12, 1, 5'd1, 1, 5'd13, 1, 0);
    chk("br_flush", 16'(flush_ifid), 16'd1);
    chk("br_stall", 16'(stall), 16'd0);
    tick();
    chk("br_ex_valid", 16'(ex_valid), 16'd0);
    chk("br_flush_cnt", 16'(flush_cnt), 16'd1);
    chk("br_stall_cnt", 16'(stall_cnt), 16'd1);
    chk("br_bubble_no_flush", 16'(flush_ifid), 16'd0);
    ex_br_taken = 1'b0;
    drive(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0);
    tick();

    // Reset mid-stall clears everything asynchronously
    drive(1, 5'd1, 1, 5'd0, 0, 5'd6, 1, 1);
    tick();
    drive(1, 5'd6, 1, 5'd6, 1, 5'd8, 1, 0);
    chk("pre_rst_stall", 16'(stall), 16'd1);
    RSTN = 1'b0;
    #1;
    chk("async_rst_stall", 16'(stall), 16'd0);
    chk("async_rst_ex_valid", 16'(ex_valid), 16'd0);
    chk("async_rst_flush_cnt", 16'(flush_cnt), 16'd0);
    chk("async_rst_stall_cnt", 16'(stall_cnt), 16'd0);
    RSTN = 1'b1;
    #1;
    tick();
    chk("post_rst_ex_valid", 16'(ex_valid), 16'd1);
    chk("post_rst_sel1", 16'(fwd_sel1), 16'd0);
    chk("post_rst_stall_cnt", 16'(stall_cnt), 16'd0);

    // Saturation: 20 load-use pairs on a 4-bit counter
    for (int i = 0; i < 20; i++) begin
      drive(1, 5'd1, 1, 5'd0, 0, 5'd6, 1, 1);
      tick();
      drive(1, 5'd6, 1, 5'd6, 1, 5'd8, 1, 0);
      tick();
      chk("sat_stall_cnt", 16'(stall_cnt), (i + 1 > 15) ? 16'd15 : 16'(i + 1));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
